// File: rtl/nms_8zone_pkg.sv
// Shared types and constants for the 8-zone Canny non-maximum suppression stage.
package nms_8zone_pkg;

  localparam int unsigned ZoneW       = 4;
  localparam int unsigned MagWDefault = 12;

  localparam logic [ZoneW-1:0] Zone1 = 4'd1;
  localparam logic [ZoneW-1:0] Zone2 = 4'd2;
  localparam logic [ZoneW-1:0] Zone3 = 4'd3;
  localparam logic [ZoneW-1:0] Zone4 = 4'd4;
  localparam logic [ZoneW-1:0] Zone5 = 4'd5;
  localparam logic [ZoneW-1:0] Zone6 = 4'd6;
  localparam logic [ZoneW-1:0] Zone7 = 4'd7;
  localparam logic [ZoneW-1:0] Zone8 = 4'd8;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  // Neighbour pair along the gradient: first named is earlier in raster order.
  typedef enum logic [2:0] {SelWe, SelNs, SelNeSw, SelNwSe, SelNone} nbr_sel_e;

  function automatic nbr_sel_e zone_to_sel(input logic [ZoneW-1:0] zone);
    unique case (zone)
      Zone1, Zone8: return SelWe;
      Zone4, Zone5: return SelNs;
      Zone2, Zone3: return SelNeSw;
      Zone6, Zone7: return SelNwSe;
      default:      return SelNone;
    endcase
  endfunction

endpackage

// File: rtl/nms_line_buf.sv
// Simple dual-port line buffer: one write and one registered read per cycle.
// A same-address read and write on one edge returns the old contents.
module nms_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nms_8zone.sv
// Canny non-maximum suppression over a 3x3 window built from two magnitude line buffers.
// Pipeline: beat edge -> RAM read / stage 1 -> window shift -> registered output.
module nms_8zone
  import nms_8zone_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned MAG_W = MagWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [ZoneW-1:0] in_zone,
  output logic             out_valid,
  output logic [MAG_W-1:0] out_mag,
  output logic [ZoneW-1:0] out_zone,
  output logic             out_sof,
  output logic             out_eol
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = $clog2(IMG_H + 2);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [RowW-1:0] RowEnd  = RowW'(IMG_H + 1);

  // Input side: FSM and beat counters
  state_e          state_q, state_d;
  logic [ColW-1:0] in_col_q, in_col_d;
  logic [RowW-1:0] in_row_q, in_row_d;
  logic            in_ready_q, in_ready_d;
  logic            flushing, beat, emit;
  logic [MAG_W-1:0] beat_mag;
  logic [ZoneW-1:0] beat_zone;

  assign flushing  = (state_q == StFlush);
  assign beat      = flushing | (in_valid & in_ready_q);
  assign emit      = beat & ((state_q == StRun) | flushing);
  assign beat_mag  = flushing ? '0 : in_mag;
  assign beat_zone = flushing ? '0 : in_zone;
  assign in_ready  = in_ready_q;

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (beat) begin
      if (in_col_q == ColLast) begin
        in_col_d = '0;
        in_row_d = in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
      unique case (state_q)
        StIdle:  state_d = StFill;
        // Beat IMG_W is the (IMG_W+1)th of the frame.
        StFill:  if (in_row_q == RowW'(1) && in_col_q == '0) state_d = StRun;
        StRun:   if (in_row_q == RowLast && in_col_q == ColLast) state_d = StFlush;
        StFlush: begin
          if (in_row_q == RowEnd) begin
            state_d  = StIdle;
            in_col_d = '0;
            in_row_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    in_ready_d = (state_d != StFlush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_col_q   <= '0;
      in_row_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Line buffers: rd_up1 = pixel one row above the beat, rd_up2 = two rows above
  logic [MAG_W-1:0] rd_up1, rd_up2;
  logic [ZoneW-1:0] rd_zone;
  logic             s1_valid_q, s1_emit_q;
  logic [MAG_W-1:0] s1_mag_q;
  logic [ColW-1:0]  s1_col_q;

  nms_line_buf #(.DEPTH(IMG_W), .WIDTH(MAG_W), .AW(ColW)) u_lb_up1 (
    .clk     (clk),
    .we_i    (beat),
    .waddr_i (in_col_q),
    .wdata_i (beat_mag),
    .re_i    (beat),
    .raddr_i (in_col_q),
    .rdata_o (rd_up1)
  );

  // Second row is written a cycle late with what the first row just returned.
  nms_line_buf #(.DEPTH(IMG_W), .WIDTH(MAG_W), .AW(ColW)) u_lb_up2 (
    .clk     (clk),
    .we_i    (s1_valid_q),
    .waddr_i (s1_col_q),
    .wdata_i (rd_up1),
    .re_i    (beat),
    .raddr_i (in_col_q),
    .rdata_o (rd_up2)
  );

  nms_line_buf #(.DEPTH(IMG_W), .WIDTH(ZoneW), .AW(ColW)) u_lb_zone (
    .clk     (clk),
    .we_i    (beat),
    .waddr_i (in_col_q),
    .wdata_i (beat_zone),
    .re_i    (beat),
    .raddr_i (in_col_q),
    .rdata_o (rd_zone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= beat;
      s1_emit_q  <= emit;
      s1_mag_q   <= beat_mag;
      s1_col_q   <= in_col_q;
    end
  end

  // 3x3 window: row 0 oldest, column 2 newest; centre is win_q[1][1]
  logic [MAG_W-1:0] win_q [3][3];
  logic [MAG_W-1:0] win_d [3][3];
  logic [ZoneW-1:0] zc_q, zc_d, zn_q, zn_d;
  logic             c_valid_q, c_valid_d;
  logic [ColW-1:0]  c_col_q, c_col_d, oc_col_q, oc_col_d;
  logic [RowW-1:0]  c_row_q, c_row_d, oc_row_q, oc_row_d;

  always_comb begin
    win_d     = win_q;
    zc_d      = zc_q;
    zn_d      = zn_q;
    c_valid_d = 1'b0;
    c_col_d   = c_col_q;
    c_row_d   = c_row_q;
    oc_col_d  = oc_col_q;
    oc_row_d  = oc_row_q;
    if (s1_valid_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd_up2;
      win_d[1][2] = rd_up1;
      win_d[2][2] = s1_mag_q;
      zc_d        = zn_q;
      zn_d        = rd_zone;
      if (s1_emit_q) begin
        c_valid_d = 1'b1;
        c_col_d   = oc_col_q;
        c_row_d   = oc_row_q;
        if (oc_col_q == ColLast) begin
          oc_col_d = '0;
          oc_row_d = (oc_row_q == RowLast) ? '0 : oc_row_q + 1'b1;
        end else begin
          oc_col_d = oc_col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '{default: '0};
      zc_q      <= '0;
      zn_q      <= '0;
      c_valid_q <= 1'b0;
      c_col_q   <= '0;
      c_row_q   <= '0;
      oc_col_q  <= '0;
      oc_row_q  <= '0;
    end else begin
      win_q     <= win_d;
      zc_q      <= zc_d;
      zn_q      <= zn_d;
      c_valid_q <= c_valid_d;
      c_col_q   <= c_col_d;
      c_row_q   <= c_row_d;
      oc_col_q  <= oc_col_d;
      oc_row_q  <= oc_row_d;
    end
  end

  // Neighbour select, compare and output register
  nbr_sel_e         sel;
  logic [MAG_W-1:0] cen, nbr_a, nbr_b;
  logic             keep, border;
  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
  logic [MAG_W-1:0] out_mag_q, out_mag_d;
  logic [ZoneW-1:0] out_zone_q, out_zone_d;

  always_comb begin
    sel   = zone_to_sel(zc_q);
    cen   = win_q[1][1];
    nbr_a = '0;
    nbr_b = '0;
    unique case (sel)
      SelWe:   begin nbr_a = win_q[1][0]; nbr_b = win_q[1][2]; end
      SelNs:   begin nbr_a = win_q[0][1]; nbr_b = win_q[2][1]; end
      SelNeSw: begin nbr_a = win_q[0][2]; nbr_b = win_q[2][0]; end
      SelNwSe: begin nbr_a = win_q[0][0]; nbr_b = win_q[2][2]; end
      default: ;
    endcase
    // Strict on the earlier neighbour, inclusive on the later one: plateaus keep one pixel.
    keep   = (sel != SelNone) && (cen > nbr_a) && (cen >= nbr_b);
    // Border masking also hides row wrap and stale line-buffer contents.
    border = (c_row_q == '0) || (c_row_q == RowLast) || (c_col_q == '0) || (c_col_q == ColLast);
    out_valid_d = c_valid_q;
    out_mag_d   = (c_valid_q && keep && !border) ? cen : '0;
    out_zone_d  = (c_valid_q && !border) ? zc_q : '0;
    out_sof_d   = c_valid_q && (c_col_q == '0) && (c_row_q == '0);
    out_eol_d   = c_valid_q && (c_col_q == ColLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_zone_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_zone_q  <= out_zone_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_zone  = out_zone_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_nms_8zone.sv
// Directed and table-driven bench for nms_8zone on an 8x6 image.
module tb_nms_8zone;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int MW   = 12;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mag = '0;
  logic [3:0]    in_zone = '0;
  logic          out_valid;
  logic [MW-1:0] out_mag;
  logic [3:0]    out_zone;
  logic          out_sof;
  logic          out_eol;

  always #5 clk = ~clk;

  nms_8zone #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_zone   (in_zone),
    .out_valid (out_valid),
    .out_mag   (out_mag),
    .out_zone  (out_zone),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  typedef struct {
    string name;
    int    kind;   // 0 vertical ridge col 3, 1 horizontal ridge row 2, 2 diagonal r==c
    int    zone;
    int    hi;
    int    lo;
    int    keep;   // ridge pixels survive suppression
  } vec_t;

  vec_t vecs[9];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc9_cyc = 0;
  int rdy_low = 0;
  int low0;
  int sof_cnt;
  int cap_mag[$], cap_zone[$], cap_sof[$], cap_eol[$], cap_cyc[$];
  int img_mag[2][H][W], img_zone[2][H][W], exp_mag[2][H][W], exp_zone[2][H][W];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!in_ready) rdy_low <= rdy_low + 1;
    if (out_valid) begin
      cap_mag.push_back(int'(out_mag));
      cap_zone.push_back(int'(out_zone));
      cap_sof.push_back(int'(out_sof));
      cap_eol.push_back(int'(out_eol));
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int cap_at(input int i);
    return (i < cap_mag.size()) ? cap_mag[i] : -1;
  endfunction

  task automatic clear_cap();
    cap_mag.delete(); cap_zone.delete(); cap_sof.delete(); cap_eol.delete(); cap_cyc.delete();
  endtask

  task automatic fill_pattern(input int s, input vec_t v);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bit on = (v.kind == 0) ? (c == 3) : (v.kind == 1) ? (r == 2) : (r == c);
        bit interior = (r > 0) && (r < H - 1) && (c > 0) && (c < W - 1);
        img_mag[s][r][c]  = on ? v.hi : v.lo;
        img_zone[s][r][c] = v.zone;
        exp_mag[s][r][c]  = (interior && on && v.keep != 0) ? v.hi : 0;
        exp_zone[s][r][c] = interior ? v.zone : 0;
      end
    end
  endtask

  // Golden NMS computed directly on the stored image.
  task automatic model(input int s);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int z = img_zone[s][r][c];
        int cv = img_mag[s][r][c];
        int a = 0;
        int b = 0;
        bit ok = 1'b1;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          exp_mag[s][r][c]  = 0;
          exp_zone[s][r][c] = 0;
        end else begin
          case (z)
            1, 8: begin a = img_mag[s][r][c-1];   b = img_mag[s][r][c+1];   end
            4, 5: begin a = img_mag[s][r-1][c];   b = img_mag[s][r+1][c];   end
            2, 3: begin a = img_mag[s][r-1][c+1]; b = img_mag[s][r+1][c-1]; end
            6, 7: begin a = img_mag[s][r-1][c-1]; b = img_mag[s][r+1][c+1]; end
            default: ok = 1'b0;
          endcase
          exp_mag[s][r][c]  = (ok && cv > a && cv >= b) ? cv : 0;
          exp_zone[s][r][c] = z;
        end
      end
    end
  endtask

  // Called aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic send(input int s, input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      int bud = 0;
      while ($urandom_range(0, 99) < gap && bud < 4) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        bud++;
      end
      in_valid = 1'b1;
      in_mag   = MW'(img_mag[s][i / W][i % W]);
      in_zone  = 4'(img_zone[s][i / W][i % W]);
      bud = 0;
      while (!in_ready && bud < 100) begin
        @(posedge clk); #1;
        bud++;
      end
      if (bud >= 100) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      if (i == 9) acc9_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int bud = 0;
    while (cap_mag.size() < n && bud < 2000) begin
      @(posedge clk);
      bud++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("output_count", cap_mag.size(), n);
  endtask

  task automatic compare(input int s, input int base, input string tag);
    for (int i = 0; i < NPIX; i++) begin
      int r = i / W;
      int c = i % W;
      if (base + i >= cap_mag.size()) break;
      chk($sformatf("%s mag r%0d c%0d", tag, r, c), cap_mag[base+i], exp_mag[s][r][c]);
      chk($sformatf("%s zone r%0d c%0d", tag, r, c), cap_zone[base+i], exp_zone[s][r][c]);
      chk($sformatf("%s sof i%0d", tag, i), cap_sof[base+i], (i == 0) ? 1 : 0);
      chk($sformatf("%s eol i%0d", tag, i), cap_eol[base+i], (c == W - 1) ? 1 : 0);
    end
  endtask

  task automatic rand_image(input int s);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[s][r][c]  = $urandom_range(0, 60);
        img_zone[s][r][c] = $urandom_range(0, 9);
      end
    model(s);
  endtask

  initial begin
    vecs[0] = '{"vridge_z1",   0, 1, 100, 10, 1};
    vecs[1] = '{"vridge_z8",   0, 8, 100, 10, 1};
    vecs[2] = '{"hridge_z4",   1, 4,  50,  5, 1};
    vecs[3] = '{"hridge_z5",   1, 5,  50,  5, 1};
    vecs[4] = '{"diag_z2",     2, 2,  80,  0, 1};
    vecs[5] = '{"diag_z6",     2, 6,  80,  0, 0};
    vecs[6] = '{"vridge_z4",   0, 4, 100, 10, 0};
    vecs[7] = '{"vridge_z0",   0, 0, 100, 10, 0};
    vecs[8] = '{"vridge_z9",   0, 9, 100, 10, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (20) begin
      @(negedge clk);
      chk("idle_flags", int'({out_valid, in_ready, out_sof, out_eol}), 4);
      chk("idle_mag_zone", int'(out_mag) + int'(out_zone), 0);
    end
    @(posedge clk); #1;

    // Directed ridge patterns
    for (int v = 0; v < 9; v++) begin
      fill_pattern(0, vecs[v]);
      clear_cap();
      send(0, 0, NPIX, 0);
      wait_outs(NPIX);
      compare(0, 0, vecs[v].name);
      if (v == 0) chk("latency", (cap_cyc.size() > 0) ? cap_cyc[0] - acc9_cyc : -1, 2);
    end

    // Tie-break cases, zone 1 (W,E)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[0][r][c]  = 0;
        img_zone[0][r][c] = 1;
      end
    img_mag[0][1][1] = 40; img_mag[0][1][2] = 40; img_mag[0][1][3] = 40;
    img_mag[0][2][1] = 39; img_mag[0][2][2] = 40; img_mag[0][2][3] = 40;
    img_mag[0][3][1] = 40; img_mag[0][3][2] = 40; img_mag[0][3][3] = 39;
    model(0);
    clear_cap();
    send(0, 0, NPIX, 0);
    wait_outs(NPIX);
    compare(0, 0, "tie");
    chk("tie_c_eq_a_eq_b", cap_at(1 * W + 2), 0);
    chk("tie_c_eq_b_gt_a", cap_at(2 * W + 2), 40);
    chk("tie_c_eq_a_gt_b", cap_at(3 * W + 2), 0);
    chk("tie_plateau_left", cap_at(1 * W + 1), 40);

    // Two back-to-back random frames with input gaps
    rand_image(0);
    rand_image(1);
    clear_cap();
    low0 = rdy_low;
    send(0, 0, NPIX, 30);
    send(1, 0, NPIX, 30);
    wait_outs(2 * NPIX);
    compare(0, 0, "rand_f1");
    compare(1, NPIX, "rand_f2");
    sof_cnt = 0;
    foreach (cap_sof[i]) sof_cnt += cap_sof[i];
    chk("sof_per_frame", sof_cnt, 2);
    chk("ready_low_cycles", rdy_low - low0, 2 * (W + 1));

    // Asynchronous reset in the middle of a frame
    rand_image(0);
    clear_cap();
    send(0, 0, 20, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_cap();
    send(0, 0, 9, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_output_before_10th_beat", cap_mag.size(), 0);
    send(0, 9, NPIX, 0);
    wait_outs(NPIX);
    compare(0, 0, "post_rst");
    chk("post_rst_latency", (cap_cyc.size() > 0) ? cap_cyc[0] - acc9_cyc : -1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
